// File: rtl/param_fir_filter.sv
// param_fir_filter: TAPS-deep time-multiplexed FIR filter with one MAC per clock.
// Signed fixed-point coefficients, saturate or wrap on overflow, and a
// block_done pulse every BLOCK_LEN results.
//
// Handshake: data_ready / load_coeff act as "valid" and !modwait acts as
// "ready". A request is taken only on a clock edge where modwait is low.
// Requests made while modwait is high are dropped (not queued, not flagged).
// If data_ready and load_coeff are both high on an accepting edge,
// data_ready wins and the coefficient write is discarded.
module param_fir_filter #(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 4,
  parameter int FRAC_BITS = 14,
  parameter int BLOCK_LEN = 1000,
  parameter int SAT_MODE  = 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic signed [DATA_W-1:0] sample_data,
  input  logic signed [DATA_W-1:0] fir_coefficient,
  input  logic                     load_coeff,
  input  logic                     data_ready,
  output logic                     modwait,
  output logic signed [DATA_W-1:0] fir_out,
  output logic                     err,
  output logic                     block_done,
  output logic [1:0]               dbg_state
);

  localparam int TW = $clog2(TAPS);
  localparam int AW = 2 * DATA_W + TW;
  localparam int CW = $clog2(BLOCK_LEN + 1);
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_LEN - 1);
  localparam logic signed [AW-1:0] MAX_V =
    {{(AW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0]   coeff_q [TAPS];
  logic signed [DATA_W-1:0]   x_q     [TAPS];
  logic        [TW-1:0]       load_idx_q;
  logic        [TW-1:0]       tap_q;
  logic signed [AW-1:0]       acc_q;
  logic        [CW-1:0]       cnt_q;
  logic signed [DATA_W-1:0]   fir_out_q;
  logic                       err_q;
  logic                       block_done_q;

  logic signed [2*DATA_W-1:0] x_ext, c_ext, prod;
  logic signed [AW-1:0]       shifted;
  logic signed [DATA_W-1:0]   res_d;
  logic                       ovf_d;

  // Full-precision product of the current tap; operands sign-extended first.
  always_comb begin
    x_ext = {{DATA_W{x_q[tap_q][DATA_W-1]}}, x_q[tap_q]};
    c_ext = {{DATA_W{coeff_q[tap_q][DATA_W-1]}}, coeff_q[tap_q]};
    prod  = x_ext * c_ext;
  end

  // Rescale the accumulator and apply overflow handling.
  always_comb begin
    shifted = acc_q >>> FRAC_BITS;
    ovf_d   = (shifted > MAX_V) || (shifted < MIN_V);
    res_d   = shifted[DATA_W-1:0];
    if (SAT_MODE != 0) begin
      if (shifted > MAX_V) res_d = {1'b0, {(DATA_W - 1){1'b1}}};
      else if (shifted < MIN_V) res_d = {1'b1, {(DATA_W - 1){1'b0}}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_ready)      state_d = S_MAC;
        else if (load_coeff) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_IDLE;
      S_MAC:   if (tap_q == LAST_TAP) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded straight from the state register.
  always_comb begin
    modwait   = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  // Datapath: coefficient file, delay line, MAC, result and block counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coeff_q[i] <= '0;
        x_q[i]     <= '0;
      end
      load_idx_q   <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      fir_out_q    <= '0;
      err_q        <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      block_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data_ready) begin
            for (int i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
            x_q[0] <= sample_data;
            acc_q  <= '0;
            tap_q  <= '0;
          end else if (load_coeff) begin
            coeff_q[load_idx_q] <= fir_coefficient;
            load_idx_q <= (load_idx_q == LAST_TAP) ? '0 : load_idx_q + 1'b1;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + $signed({{TW{prod[2*DATA_W-1]}}, prod});
          tap_q <= (tap_q == LAST_TAP) ? '0 : tap_q + 1'b1;
        end
        S_OUT: begin
          fir_out_q <= res_d;
          err_q     <= ovf_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q        <= '0;
            block_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fir_out    = fir_out_q;
  assign err        = err_q;
  assign block_done = block_done_q;

endmodule
